// File: rtl/snn_pkg.sv
// snn_pkg: types and saturation helpers shared by the synapse front-end and the LIF neuron.
package snn_pkg;
    localparam int CUR_WIDTH_DEF = 8;
    localparam int W_WIDTH_DEF = 8;

    typedef logic [CUR_WIDTH_DEF-1:0] current_t;

    typedef struct packed {
        logic                   inh;
        logic [W_WIDTH_DEF-1:0] mag;
    } weight_t;

    function automatic logic signed [31:0] cur_max(input int width);
        return (32'sd1 <<< width) - 32'sd1;
    endfunction

    function automatic logic [31:0] clamp_u(input logic signed [31:0] v, input int width);
        if (v < 0) return '0;
        return v > cur_max(width) ? cur_max(width) : v;
    endfunction

    function automatic logic clamps_high(input logic signed [31:0] v, input int width);
        return v > cur_max(width);
    endfunction
endpackage

// File: rtl/synapse_weight_bank.sv
// synapse_weight_bank: weight/inhibit register file behind a valid/ready port accepting one write per two cycles.
module synapse_weight_bank
    import snn_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8,
    localparam int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [AW-1:0]  wr_addr,
    input  logic [W-1:0]   wr_data,
    input  logic           wr_inh,
    output logic [N*W-1:0] weights,
    output logic [N-1:0]   inh
);
    // Out-of-range addresses still complete the handshake so the writer never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weights  <= '0;
            inh      <= '0;
            wr_ready <= 1'b1;
        end else if (wr_valid && wr_ready) begin
            wr_ready <= 1'b0;
            if (32'(wr_addr) < N) begin
                weights[wr_addr*W +: W] <= wr_data;
                inh[wr_addr]            <= wr_inh;
            end
        end else begin
            wr_ready <= 1'b1;
        end
    end
endmodule

// File: rtl/synaptic_current.sv
// synaptic_current: weighted spike summation into a decaying, saturating current for the LIF neuron.
module synaptic_current
    import snn_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int W_WIDTH = W_WIDTH_DEF,
    parameter int CUR_WIDTH = CUR_WIDTH_DEF,
    parameter int DECAY_SHIFT = 1,
    parameter int DECAY_PERIOD = 4,
    localparam int AW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N_INPUTS-1:0]  spike_in,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [AW-1:0]        wr_addr,
    input  logic [W_WIDTH-1:0]   wr_data,
    input  logic                 wr_inh,
    output logic [CUR_WIDTH-1:0] current,
    output logic                 sat
);
    localparam int SW = W_WIDTH + $clog2(N_INPUTS);
    localparam int ACC_W = CUR_WIDTH + W_WIDTH + 2;
    localparam int PW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

    logic [N_INPUTS*W_WIDTH-1:0] weights;
    logic [N_INPUTS-1:0]         inh;
    logic [SW-1:0]               exc_sum, inh_sum, exc_q, inh_q;
    logic [PW-1:0]               pcnt;
    logic                        tick;
    logic [CUR_WIDTH-1:0]        dec;
    logic signed [ACC_W-1:0]     acc_next;
    logic signed [31:0]          acc_wide;

    synapse_weight_bank #(.N(N_INPUTS), .W(W_WIDTH)) bank (
        .clk(clk),
        .rst(rst),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_inh(wr_inh),
        .weights(weights),
        .inh(inh)
    );

    always_comb begin
        exc_sum = '0;
        inh_sum = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            exc_sum += (spike_in[i] && !inh[i]) ? SW'(weights[i*W_WIDTH +: W_WIDTH]) : '0;
            inh_sum += (spike_in[i] && inh[i]) ? SW'(weights[i*W_WIDTH +: W_WIDTH]) : '0;
        end
    end

    // A shift that rounds to zero still removes one unit so the current always decays fully.
    assign tick = pcnt == PW'(DECAY_PERIOD - 1);
    assign dec = !tick ? '0 :
                 (current >> DECAY_SHIFT) != '0 ? current >> DECAY_SHIFT : CUR_WIDTH'(current != '0);
    assign acc_next = ACC_W'(current) - ACC_W'(dec) + ACC_W'(exc_q) - ACC_W'(inh_q);
    assign acc_wide = 32'(acc_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_q   <= '0;
            inh_q   <= '0;
            pcnt    <= '0;
            current <= '0;
            sat     <= 1'b0;
        end else if (en) begin
            exc_q   <= exc_sum;
            inh_q   <= inh_sum;
            pcnt    <= tick ? '0 : pcnt + 1'b1;
            current <= CUR_WIDTH'(clamp_u(acc_wide, CUR_WIDTH));
            sat     <= clamps_high(acc_wide, CUR_WIDTH);
        end else begin
            sat <= 1'b0;
        end
    end
endmodule

// File: tb/tb_synaptic_current.sv
// tb_synaptic_current: directed tables plus random stimulus against a cycle-level arithmetic model.
module tb_synaptic_current;
    localparam int N = 4;
    localparam int P = 4;

    logic       clk = 1'b0, rst = 1'b1, en = 1'b1;
    logic [3:0] spike = '0;
    logic       wr_valid = 1'b0, wr_ready, wr_inh = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0, current;
    logic       sat;

    logic [2:0] spike3 = '0;
    logic       wv3 = 1'b0, rdy3, inh3 = 1'b0;
    logic [1:0] a3 = '0;
    logic [7:0] d3 = '0, cur3;
    logic       sat3;

    synaptic_current dut (
        .clk(clk), .rst(rst), .en(en), .spike_in(spike), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_inh(wr_inh), .current(current), .sat(sat)
    );

    synaptic_current #(.N_INPUTS(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .spike_in(spike3), .wr_valid(wv3), .wr_ready(rdy3),
        .wr_addr(a3), .wr_data(d3), .wr_inh(inh3), .current(cur3), .sat(sat3)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int m_acc, m_eq, m_iq, m_cnt, m_ready, m_sat;
    int m_w[N], m_h[N];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_acc = 0; m_eq = 0; m_iq = 0; m_cnt = 0; m_ready = 1; m_sat = 0;
        for (int i = 0; i < N; i++) begin
            m_w[i] = 0;
            m_h[i] = 0;
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        int e, h, d, nx;
        @(posedge clk);
        if (en) begin
            e = 0;
            h = 0;
            for (int i = 0; i < N; i++)
                if (spike[i]) begin
                    if (m_h[i] != 0) h += m_w[i];
                    else e += m_w[i];
                end
            d = 0;
            if (m_cnt == P - 1) begin
                d = m_acc / 2;
                if (d == 0 && m_acc != 0) d = 1;
            end
            nx = m_acc - d + m_eq - m_iq;
            m_sat = nx > 255 ? 1 : 0;
            m_acc = nx < 0 ? 0 : (nx > 255 ? 255 : nx);
            m_eq = e;
            m_iq = h;
            m_cnt = (m_cnt + 1) % P;
        end else begin
            m_sat = 0;
        end
        if (wr_valid && m_ready != 0) begin
            m_ready = 0;
            if (int'(wr_addr) < N) begin
                m_w[wr_addr] = int'(wr_data);
                m_h[wr_addr] = int'(wr_inh);
            end
        end else begin
            m_ready = 1;
        end
        #1;
        chk("current", int'(current), m_acc);
        chk("sat", int'(sat), m_sat);
        chk("wr_ready", int'(wr_ready), m_ready);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wr(input int a, input int d, input bit h);
        wr_valid = 1'b1;
        wr_addr = 2'(a);
        wr_data = 8'(d);
        wr_inh = h;
        step();
        wr_valid = 1'b0;
        step();
    endtask

    typedef struct {
        logic [3:0] sp;
        logic       wv;
        logic [7:0] data;
        int         cur;
        logic       rdy;
    } vec_t;

    vec_t vec[8];
    int   decay_exp[6] = '{10, 5, 3, 2, 1, 0};
    int   nsat, held;

    initial begin
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_current", int'(current), 0);
        chk("reset_sat", int'(sat), 0);
        chk("reset_ready", int'(wr_ready), 1);
        chk("reset_ready3", int'(rdy3), 1);

        // zero weights on the main block; out-of-range write on the 3-input block
        spike = 4'hF;
        wv3 = 1'b1; a3 = 2'd0; d3 = 8'd10;
        step();
        wv3 = 1'b0;
        step();
        wv3 = 1'b1; a3 = 2'd3; d3 = 8'd99;
        step();
        chk("oob_ready_drop", int'(rdy3), 0);
        wv3 = 1'b0;
        step();
        chk("oob_ready_back", int'(rdy3), 1);
        spike3 = 3'b111;
        step();
        spike3 = 3'b000;
        step();
        chk("oob_no_change", int'(cur3), 10);
        spike = 4'h0;

        // write w0=40 then a single spike, followed by the full decay staircase
        do_reset();
        vec[0] = '{4'h0, 1'b1, 8'd40, 0, 1'b0};
        vec[1] = '{4'h0, 1'b0, 8'd0, 0, 1'b1};
        vec[2] = '{4'h0, 1'b0, 8'd0, 0, 1'b1};
        vec[3] = '{4'h0, 1'b0, 8'd0, 0, 1'b1};
        vec[4] = '{4'h1, 1'b0, 8'd0, 0, 1'b1};
        vec[5] = '{4'h0, 1'b0, 8'd0, 40, 1'b1};
        vec[6] = '{4'h0, 1'b0, 8'd0, 40, 1'b1};
        vec[7] = '{4'h0, 1'b0, 8'd0, 20, 1'b1};
        for (int i = 0; i < 8; i++) begin
            spike = vec[i].sp;
            wr_valid = vec[i].wv;
            wr_addr = 2'd0;
            wr_data = vec[i].data;
            wr_inh = 1'b0;
            step();
            chk($sformatf("tbl%0d_cur", i), int'(current), vec[i].cur);
            chk($sformatf("tbl%0d_rdy", i), int'(wr_ready), int'(vec[i].rdy));
        end
        wr_valid = 1'b0;
        spike = 4'h0;
        for (int k = 0; k < 6; k++) begin
            repeat (4) step();
            chk($sformatf("decay%0d", k), int'(current), decay_exp[k]);
        end

        // saturation with all four weights at 100
        do_reset();
        for (int a = 0; a < 4; a++) wr(a, 100, 1'b0);
        nsat = 0;
        spike = 4'hF;
        for (int s = 1; s <= 15; s++) begin
            if (s == 4) spike = 4'h0;
            step();
            nsat += int'(sat);
            if (s == 2) chk("sat_peak", int'(current), 255);
            if (s == 5) chk("sat_hold", int'(current), 255);
        end
        chk("sat_pulses", nsat, 3);

        // inhibition and clamp-low
        do_reset();
        wr(0, 40, 1'b0);
        wr(1, 60, 1'b1);
        spike = 4'h1; step();
        spike = 4'h0; step();
        step();
        spike = 4'h2; step();
        spike = 4'h0; step();
        chk("inh_to_zero", int'(current), 0);
        chk("inh_no_sat", int'(sat), 0);
        spike = 4'h3; step();
        spike = 4'h0; step();
        chk("clamp_low", int'(current), 0);

        // back-to-back write requests with wr_valid held high
        wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 8'd7; wr_inh = 1'b0;
        step();
        chk("hs_first", int'(wr_ready), 0);
        wr_addr = 2'd3; wr_data = 8'd9;
        step();
        chk("hs_gap", int'(wr_ready), 1);
        step();
        chk("hs_second", int'(wr_ready), 0);
        wr_valid = 1'b0;
        step();

        // spike in the same cycle as a weight write uses the old weight
        wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 8'd200; wr_inh = 1'b0;
        spike = 4'h1;
        step();
        wr_valid = 1'b0;
        spike = 4'h0;
        repeat (2) step();
        spike = 4'h1; step();
        spike = 4'h0; step();

        // en low freezes the datapath even with spikes present
        held = int'(current);
        en = 1'b0;
        spike = 4'hF;
        repeat (8) begin
            step();
            chk("freeze", int'(current), held);
        end
        en = 1'b1;
        spike = 4'h0;
        repeat (3) step();

        // asynchronous reset in the middle of a cycle
        do_reset();
        wr(0, 200, 1'b0);
        spike = 4'h1; step();
        spike = 4'h0; step();
        chk("pre_async", int'(current), 200);
        #2;
        rst = 1'b1;
        #1;
        chk("async_current", int'(current), 0);
        chk("async_ready", int'(wr_ready), 1);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        spike = 4'h1; step();
        spike = 4'h0; step();
        chk("weights_cleared", int'(current), 0);

        // randomized traffic
        do_reset();
        repeat (400) begin
            en = $urandom_range(0, 9) != 0;
            spike = 4'($urandom);
            wr_valid = $urandom_range(0, 3) == 0;
            wr_addr = 2'($urandom);
            wr_data = 8'($urandom);
            wr_inh = 1'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
